// File: rtl/fft8_frame_ctrl_if.sv
// Sample-in / bin-out handshake bundle of the 8-point FFT frame sequencer.
// master: the sequencer side; slave: the source/sink environment side.
interface fft8_frame_ctrl_if #(
  parameter int unsigned DW = 16
);
  logic          s_valid;
  logic          s_ready;
  logic          s_first;
  logic          s_mode;
  logic [DW-1:0] s_data_r;
  logic [DW-1:0] s_data_i;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data_r;
  logic [DW-1:0] m_data_i;
  logic [2:0]    m_index;
  logic          m_last;
  logic          m_mode;

  modport master (
    input  s_valid, s_first, s_mode, s_data_r, s_data_i, m_ready,
    output s_ready, m_valid, m_data_r, m_data_i, m_index, m_last, m_mode
  );

  modport slave (
    output s_valid, s_first, s_mode, s_data_r, s_data_i, m_ready,
    input  s_ready, m_valid, m_data_r, m_data_i, m_index, m_last, m_mode
  );
endinterface

// File: rtl/fft8_frame_ctrl.sv
// Frame sequencer for the pipelined 8-point FFT/IFFT core: fills, runs, captures, drains.
// Optional FFT8_FRAME_CNT_EN adds a 16-bit count of fully drained frames.
module fft8_frame_ctrl #(
  parameter int unsigned DW           = 16,
  parameter int unsigned CORE_LATENCY = 4
) (
  input  logic                clk,
  input  logic                reset,
  fft8_frame_ctrl_if.master   bus,
  output logic                core_mode,
  output logic [8*DW-1:0]     core_xr,
  output logic [8*DW-1:0]     core_xi,
  input  logic [8*DW-1:0]     core_yr,
  input  logic [8*DW-1:0]     core_yi,
  output logic                err_sync
`ifdef FFT8_FRAME_CNT_EN
  ,
  output logic [15:0]         frame_cnt
`endif
);

  localparam int unsigned NS = 8;
  localparam int unsigned PW = 3;
  localparam int unsigned CW = (CORE_LATENCY < 1) ? 1 : $clog2(CORE_LATENCY + 1);

  typedef enum logic [1:0] {ST_FILL, ST_FULL, ST_RUN} state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, wr_idx;
  logic [CW-1:0] wait_q, wait_d;
  logic [DW-1:0] in_r_q  [NS];
  logic [DW-1:0] in_r_d  [NS];
  logic [DW-1:0] in_i_q  [NS];
  logic [DW-1:0] in_i_d  [NS];
  logic [DW-1:0] out_r_q [NS];
  logic [DW-1:0] out_r_d [NS];
  logic [DW-1:0] out_i_q [NS];
  logic [DW-1:0] out_i_d [NS];
  logic          frame_mode_q, frame_mode_d;
  logic          full_q, full_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [DW-1:0] m_data_r_q, m_data_r_d;
  logic [DW-1:0] m_data_i_q, m_data_i_d;
  logic          m_last_q, m_last_d;
  logic          m_mode_q, m_mode_d;
  logic          err_q, err_d;
  logic          s_ready_q, s_ready_d;

  logic accept, realign, hs, drain, empty_nx, capture;

  // Handshake and event decode shared by both halves of the datapath
  assign accept   = (state_q == ST_FILL) && bus.s_valid;
  assign realign  = accept && bus.s_first && (wr_ptr_q != '0);
  assign hs       = full_q && bus.m_ready;
  assign drain    = hs && (rd_ptr_q == PW'(NS - 1));
  assign empty_nx = !full_q || drain;
  assign capture  = (state_q == ST_RUN) && (wait_q == CW'(CORE_LATENCY));

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    wr_idx       = wr_ptr_q;
    wait_d       = wait_q;
    in_r_d       = in_r_q;
    in_i_d       = in_i_q;
    out_r_d      = out_r_q;
    out_i_d      = out_i_q;
    frame_mode_d = frame_mode_q;
    full_d       = full_q;
    rd_ptr_d     = rd_ptr_q;
    m_data_r_d   = m_data_r_q;
    m_data_i_d   = m_data_i_q;
    m_last_d     = m_last_q;
    m_mode_d     = m_mode_q;
    err_d        = 1'b0;

    unique case (state_q)
      ST_FILL: begin
        if (accept) begin
          wr_idx         = realign ? '0 : wr_ptr_q;
          in_r_d[wr_idx] = bus.s_data_r;
          in_i_d[wr_idx] = bus.s_data_i;
          if (wr_idx == '0) frame_mode_d = bus.s_mode;
          if (realign) begin
            wr_ptr_d = PW'(1);
            err_d    = 1'b1;
          end else begin
            wr_ptr_d = wr_ptr_q + PW'(1);
            if (wr_ptr_q == PW'(NS - 1)) state_d = empty_nx ? ST_RUN : ST_FULL;
          end
        end
      end
      ST_FULL: begin
        if (empty_nx) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (capture) begin
          state_d = ST_FILL;
          wait_d  = '0;
        end else begin
          wait_d = wait_q + CW'(1);
        end
      end
      default: state_d = ST_FILL;
    endcase

    // Output side: advance the read pointer and preload the next bin
    if (hs) begin
      rd_ptr_d   = rd_ptr_q + PW'(1);
      m_data_r_d = out_r_q[rd_ptr_q + PW'(1)];
      m_data_i_d = out_i_q[rd_ptr_q + PW'(1)];
      m_last_d   = (rd_ptr_q == PW'(NS - 2));
      if (drain) full_d = 1'b0;
    end

    // Capture only ever lands on an empty buffer, so it simply overrides
    if (capture) begin
      for (int unsigned k = 0; k < NS; k++) begin
        out_r_d[k] = core_yr[k*DW +: DW];
        out_i_d[k] = core_yi[k*DW +: DW];
      end
      full_d     = 1'b1;
      rd_ptr_d   = '0;
      m_mode_d   = frame_mode_q;
      m_data_r_d = core_yr[DW-1:0];
      m_data_i_d = core_yi[DW-1:0];
      m_last_d   = 1'b0;
    end

    s_ready_d = (state_d == ST_FILL);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_FILL;
      wr_ptr_q     <= '0;
      wait_q       <= '0;
      in_r_q       <= '{default: '0};
      in_i_q       <= '{default: '0};
      out_r_q      <= '{default: '0};
      out_i_q      <= '{default: '0};
      frame_mode_q <= 1'b0;
      full_q       <= 1'b0;
      rd_ptr_q     <= '0;
      m_data_r_q   <= '0;
      m_data_i_q   <= '0;
      m_last_q     <= 1'b0;
      m_mode_q     <= 1'b0;
      err_q        <= 1'b0;
      s_ready_q    <= 1'b1;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      wait_q       <= wait_d;
      in_r_q       <= in_r_d;
      in_i_q       <= in_i_d;
      out_r_q      <= out_r_d;
      out_i_q      <= out_i_d;
      frame_mode_q <= frame_mode_d;
      full_q       <= full_d;
      rd_ptr_q     <= rd_ptr_d;
      m_data_r_q   <= m_data_r_d;
      m_data_i_q   <= m_data_i_d;
      m_last_q     <= m_last_d;
      m_mode_q     <= m_mode_d;
      err_q        <= err_d;
      s_ready_q    <= s_ready_d;
    end
  end

  for (genvar g = 0; g < NS; g++) begin : g_pack
    assign core_xr[g*DW +: DW] = in_r_q[g];
    assign core_xi[g*DW +: DW] = in_i_q[g];
  end

  assign core_mode    = frame_mode_q;
  assign err_sync     = err_q;
  assign bus.s_ready  = s_ready_q;
  assign bus.m_valid  = full_q;
  assign bus.m_data_r = m_data_r_q;
  assign bus.m_data_i = m_data_i_q;
  assign bus.m_index  = rd_ptr_q;
  assign bus.m_last   = m_last_q;
  assign bus.m_mode   = m_mode_q;

`ifdef FFT8_FRAME_CNT_EN
  logic [15:0] frame_cnt_q, frame_cnt_d;

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (drain) frame_cnt_d = frame_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) frame_cnt_q <= '0;
    else       frame_cnt_q <= frame_cnt_d;
  end

  assign frame_cnt = frame_cnt_q;
`endif

endmodule
